// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//
// Game scoring engine. Converts per-note hit events into:
//   - a saturating running score,
//   - a combo count,
//   - a multiplier,
//   - remaining lives.
// It also keeps the best completed-game score since reset.
//
// Ports
//   CLK          in   system clock, all state updates on the rising edge
//   RST          in   asynchronous, active-high reset
//   START        in   pulse; begins a new game from IDLE or OVER
//   HIT_VALID    in   strobe; HIT_GRADE is valid this cycle
//   HIT_GRADE    in   2'b00 MISS, 2'b01 GOOD, 2'b10 PERFECT, 2'b11 reserved
//   SHOW_HIGH    in   level; selects HIGH_SCORE onto BINARY_SCORE
//   BINARY_SCORE out  32-bit display bus (SHOW_HIGH ? HIGH_SCORE : SCORE)
//   SCORE        out  current game score
//   HIGH_SCORE   out  best completed-game score
//   COMBO        out  consecutive non-miss hits (saturates at 255)
//   MULT         out  current multiplier, 1..MAX_MULT
//   LIVES        out  remaining lives
//   GAME_OVER    out  high while in the OVER state
// ---------------------------------------------------------------------------
module score_keeper #(
    parameter int unsigned MAX_SCORE   = 99999999,
    parameter int unsigned PTS_PERFECT = 100,
    parameter int unsigned PTS_GOOD    = 50,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4,
    parameter int unsigned MAX_LIVES   = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        HIT_VALID,
    input  logic [1:0]  HIT_GRADE,
    input  logic        SHOW_HIGH,
    output logic [31:0] BINARY_SCORE,
    output logic [31:0] SCORE,
    output logic [31:0] HIGH_SCORE,
    output logic [7:0]  COMBO,
    output logic [2:0]  MULT,
    output logic [1:0]  LIVES,
    output logic        GAME_OVER
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam logic [32:0] MAX_SCORE_W = 33'(MAX_SCORE);
    localparam logic [1:0]  GRADE_MISS  = 2'b00;
    localparam logic [1:0]  GRADE_GOOD  = 2'b01;
    localparam logic [1:0]  GRADE_PERF  = 2'b10;

    state_t      state_q;
    logic [31:0] score_q;
    logic [31:0] high_q;
    logic [7:0]  combo_q;
    logic [2:0]  mult_q;
    logic [1:0]  lives_q;
    logic        game_over_q;

    // Next values for a scoring (GOOD/PERFECT) hit.
    logic [31:0] base_pts;
    logic [32:0] sum_w;
    logic [31:0] score_d;
    logic [7:0]  combo_d;
    logic [8:0]  mult_raw;
    logic [2:0]  mult_d;

    always_comb begin
        base_pts = (HIT_GRADE == GRADE_PERF) ? 32'(PTS_PERFECT) : 32'(PTS_GOOD);
        // One spare bit so the compare sees the true sum, never a wrapped one.
        sum_w    = {1'b0, score_q} + {1'b0, base_pts * {29'd0, mult_q}};
        score_d  = (sum_w > MAX_SCORE_W) ? MAX_SCORE_W[31:0] : sum_w[31:0];
        combo_d  = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
        // The multiplier tracks the post-increment combo.
        mult_raw = 9'd1 + {1'b0, combo_d / 8'(COMBO_STEP)};
        mult_d   = (mult_raw > 9'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            score_q     <= 32'd0;
            high_q      <= 32'd0;
            combo_q     <= 8'd0;
            mult_q      <= 3'd1;
            lives_q     <= 2'd0;
            game_over_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    // A hit arriving together with START is dropped.
                    if (START) begin
                        state_q     <= S_PLAY;
                        score_q     <= 32'd0;
                        combo_q     <= 8'd0;
                        mult_q      <= 3'd1;
                        lives_q     <= 2'(MAX_LIVES);
                        game_over_q <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (HIT_VALID) begin
                        case (HIT_GRADE)
                            GRADE_PERF, GRADE_GOOD: begin
                                score_q <= score_d;
                                combo_q <= combo_d;
                                mult_q  <= mult_d;
                            end
                            GRADE_MISS: begin
                                combo_q <= 8'd0;
                                mult_q  <= 3'd1;
                                if (lives_q != 2'd0) begin
                                    lives_q <= lives_q - 2'd1;
                                end
                                // Losing the last life closes the game and
                                // banks the score as a candidate high score.
                                if (lives_q == 2'd1) begin
                                    state_q     <= S_OVER;
                                    game_over_q <= 1'b1;
                                    if (score_q > high_q) begin
                                        high_q <= score_q;
                                    end
                                end
                            end
                            default: ; // reserved grade: no effect
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SCORE        = score_q;
    assign HIGH_SCORE   = high_q;
    assign COMBO        = combo_q;
    assign MULT         = mult_q;
    assign LIVES        = lives_q;
    assign GAME_OVER    = game_over_q;
    assign BINARY_SCORE = SHOW_HIGH ? high_q : score_q;

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
//
// Directed bench for score_keeper. Two instances share the stimulus:
//   dut      default parameters
//   dut_sat  MAX_SCORE = 1050, used for the saturation checks
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_score_keeper;

    localparam logic [1:0] G_MISS = 2'b00;
    localparam logic [1:0] G_GOOD = 2'b01;
    localparam logic [1:0] G_PERF = 2'b10;
    localparam logic [1:0] G_RSVD = 2'b11;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        HIT_VALID = 1'b0;
    logic [1:0]  HIT_GRADE = 2'b00;
    logic        SHOW_HIGH = 1'b0;

    logic [31:0] BINARY_SCORE, SCORE, HIGH_SCORE;
    logic [7:0]  COMBO;
    logic [2:0]  MULT;
    logic [1:0]  LIVES;
    logic        GAME_OVER;

    logic [31:0] s_BINARY_SCORE, s_SCORE, s_HIGH_SCORE;
    logic [7:0]  s_COMBO;
    logic [2:0]  s_MULT;
    logic [1:0]  s_LIVES;
    logic        s_GAME_OVER;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    score_keeper dut (
        .CLK(CLK), .RST(RST), .START(START), .HIT_VALID(HIT_VALID),
        .HIT_GRADE(HIT_GRADE), .SHOW_HIGH(SHOW_HIGH),
        .BINARY_SCORE(BINARY_SCORE), .SCORE(SCORE), .HIGH_SCORE(HIGH_SCORE),
        .COMBO(COMBO), .MULT(MULT), .LIVES(LIVES), .GAME_OVER(GAME_OVER)
    );

    score_keeper #(.MAX_SCORE(1050)) dut_sat (
        .CLK(CLK), .RST(RST), .START(START), .HIT_VALID(HIT_VALID),
        .HIT_GRADE(HIT_GRADE), .SHOW_HIGH(SHOW_HIGH),
        .BINARY_SCORE(s_BINARY_SCORE), .SCORE(s_SCORE), .HIGH_SCORE(s_HIGH_SCORE),
        .COMBO(s_COMBO), .MULT(s_MULT), .LIVES(s_LIVES), .GAME_OVER(s_GAME_OVER)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-22s observed=%0d expected=%0d ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n back-to-back strobes of one grade; returns on a falling edge.
    task automatic hits(input int n, input logic [1:0] grade);
        @(negedge CLK);
        HIT_VALID = 1'b1;
        HIT_GRADE = grade;
        repeat (n) @(negedge CLK);
        HIT_VALID = 1'b0;
    endtask

    task automatic start_pulse(input logic with_hit);
        @(negedge CLK);
        START     = 1'b1;
        HIT_VALID = with_hit;
        HIT_GRADE = G_PERF;
        @(negedge CLK);
        START     = 1'b0;
        HIT_VALID = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_score", SCORE, 0);
        chk("rst_high", HIGH_SCORE, 0);
        chk("rst_combo", {24'd0, COMBO}, 0);
        chk("rst_mult", {29'd0, MULT}, 1);
        chk("rst_lives", {30'd0, LIVES}, 0);
        chk("rst_over", {31'd0, GAME_OVER}, 0);
        chk("rst_bin", BINARY_SCORE, 0);
        RST = 1'b0;

        // Hits in IDLE are ignored
        hits(1, G_PERF);
        chk("idle_hit_score", SCORE, 0);

        // Game 1
        start_pulse(1'b0);
        chk("start_lives", {30'd0, LIVES}, 3);
        hits(10, G_PERF);
        chk("p10_score", SCORE, 1000);
        chk("p10_combo", {24'd0, COMBO}, 10);
        chk("p10_mult", {29'd0, MULT}, 2);
        hits(1, G_PERF);
        chk("p11_score", SCORE, 1200);
        chk("p11_combo", {24'd0, COMBO}, 11);
        hits(29, G_PERF);
        chk("p40_score", SCORE, 10000);
        chk("p40_mult", {29'd0, MULT}, 4);
        chk("p40_bin", BINARY_SCORE, 10000);
        SHOW_HIGH = 1'b1;
        #1;
        chk("p40_bin_high", BINARY_SCORE, 0);
        SHOW_HIGH = 1'b0;
        hits(10, G_PERF);
        chk("p50_score", SCORE, 14000);
        chk("p50_mult", {29'd0, MULT}, 4);
        hits(1, G_GOOD);
        chk("good_score", SCORE, 14200);
        chk("good_combo", {24'd0, COMBO}, 51);
        hits(1, G_MISS);
        chk("miss1_combo", {24'd0, COMBO}, 0);
        chk("miss1_mult", {29'd0, MULT}, 1);
        chk("miss1_lives", {30'd0, LIVES}, 2);
        chk("miss1_score", SCORE, 14200);
        hits(2, G_MISS);
        chk("g1_lives", {30'd0, LIVES}, 0);
        chk("g1_over", {31'd0, GAME_OVER}, 1);
        chk("g1_high", HIGH_SCORE, 14200);
        chk("sat_g1_high", s_HIGH_SCORE, 1050);
        SHOW_HIGH = 1'b1;
        #1;
        chk("g1_bin_high", BINARY_SCORE, 14200);
        SHOW_HIGH = 1'b0;

        // In OVER, hits are ignored
        hits(1, G_PERF);
        chk("over_hit_score", SCORE, 14200);
        chk("over_hit_combo", {24'd0, COMBO}, 0);

        // START with a simultaneous hit: hit discarded
        start_pulse(1'b1);
        chk("g2_score", SCORE, 0);
        chk("g2_lives", {30'd0, LIVES}, 3);
        chk("g2_combo", {24'd0, COMBO}, 0);
        chk("g2_over", {31'd0, GAME_OVER}, 0);
        chk("g2_high", HIGH_SCORE, 14200);

        // Game 2: COMBO=15, MULT=2, then lose it lower than game 1
        hits(15, G_PERF);
        chk("g2_p15_score", SCORE, 2000);
        chk("g2_p15_mult", {29'd0, MULT}, 2);
        hits(1, G_MISS);
        chk("g2_miss_combo", {24'd0, COMBO}, 0);
        chk("g2_miss_lives", {30'd0, LIVES}, 2);
        chk("g2_miss_score", SCORE, 2000);
        start_pulse(1'b0);
        chk("play_start_lives", {30'd0, LIVES}, 2);
        chk("play_start_score", SCORE, 2000);
        hits(2, G_MISS);
        chk("g2_over", {31'd0, GAME_OVER}, 1);
        chk("g2_high_kept", HIGH_SCORE, 14200);
        chk("g2_bin", BINARY_SCORE, 2000);

        // Game 3: saturation on the 1050-ceiling instance
        start_pulse(1'b0);
        hits(11, G_PERF);
        chk("g3_score", SCORE, 1200);
        chk("sat_score11", s_SCORE, 1050);
        hits(2, G_PERF);
        chk("g3_score13", SCORE, 1600);
        chk("sat_score13", s_SCORE, 1050);
        chk("sat_combo13", {24'd0, s_COMBO}, 13);

        // Reserved grade: no register changes
        hits(1, G_RSVD);
        chk("rsvd_score", SCORE, 1600);
        chk("rsvd_combo", {24'd0, COMBO}, 13);
        chk("rsvd_mult", {29'd0, MULT}, 2);
        chk("rsvd_lives", {30'd0, LIVES}, 3);

        // Asynchronous reset between edges
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_score", SCORE, 0);
        chk("arst_high", HIGH_SCORE, 0);
        chk("arst_combo", {24'd0, COMBO}, 0);
        chk("arst_mult", {29'd0, MULT}, 1);
        chk("arst_lives", {30'd0, LIVES}, 0);
        chk("arst_over", {31'd0, GAME_OVER}, 0);
        #1 RST = 1'b0;
        start_pulse(1'b0);
        hits(1, G_PERF);
        chk("post_rst_score", SCORE, 100);
        chk("post_rst_lives", {30'd0, LIVES}, 3);
        chk("post_rst_high", HIGH_SCORE, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game scoring engine. Turns per-note hit events from the game/judgement logic into a running decimal-range score, combo count, multiplier and lives.
- Holds a session high score.
- Drives the 32-bit binary score bus consumed directly by the 8-digit 7-segment display controller, which performs binary-to-BCD conversion and multiplexing downstream.

Parameters:
- MAX_SCORE, 99999999: saturation ceiling; the display shows at most 8 decimal digits.
- PTS_PERFECT, 100: base points for a PERFECT hit.
- PTS_GOOD, 50: base points for a GOOD hit.
- COMBO_STEP, 10: consecutive non-miss hits per multiplier increment.
- MAX_MULT, 4: multiplier ceiling (1..MAX_MULT).
- MAX_LIVES, 3: lives at game start (1..3).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  single-cycle pulse; begins a new game from IDLE or OVER.
- HIT_VALID  in  1  single-cycle strobe; HIT_GRADE is valid this cycle.
- HIT_GRADE  in  2  00 MISS, 01 GOOD, 10 PERFECT, 11 reserved.
- SHOW_HIGH  in  1  level; 1 selects HIGH_SCORE onto BINARY_SCORE.
- BINARY_SCORE  out  32  display bus = SHOW_HIGH ? HIGH_SCORE : SCORE (combinational mux of registers).
- SCORE  out  32  current game score, registered.
- HIGH_SCORE  out  32  best completed-game score since reset, registered.
- COMBO  out  8  consecutive non-miss hits, registered.
- MULT  out  3  current multiplier, registered.
- LIVES  out  2  remaining lives, registered.
- GAME_OVER  out  1  high while in OVER state.

Behaviour:
- Clock and reset: reset RST, asynchronous, active-high; clock CLK. All registers update on the CLK rising edge only.
- Reset values: state IDLE; SCORE=0, HIGH_SCORE=0, COMBO=0, MULT=1, LIVES=0, GAME_OVER=0. BINARY_SCORE therefore reads 0.
- States: IDLE, PLAY, OVER.
  - IDLE --START--> PLAY.
  - PLAY --(MISS that takes LIVES 1->0)--> OVER.
  - OVER --START--> PLAY.
  - START while in PLAY is ignored.
- Game start (the edge where START is sampled in IDLE/OVER): SCORE=0, COMBO=0, MULT=1, LIVES=MAX_LIVES, GAME_OVER=0. HIGH_SCORE is retained. A HIT_VALID in the same cycle as START is discarded.
- HIT_VALID is acted on only in PLAY; ignored in IDLE/OVER. Grade 11 is ignored entirely: no register changes.
- PERFECT/GOOD in PLAY:
  - SCORE <= min(SCORE + base*MULT, MAX_SCORE). MULT is the pre-update register value; base is PTS_PERFECT or PTS_GOOD.
  - The sum is computed 33 bits wide before the compare, so there is no wrap-around.
  - COMBO <= COMBO+1, saturating at 255.
  - MULT <= min(1 + (new COMBO / COMBO_STEP), MAX_MULT).
- MISS in PLAY: COMBO <= 0, MULT <= 1, LIVES <= LIVES-1, SCORE unchanged.
  - If the pre-update LIVES == 1: state <= OVER and GAME_OVER <= 1 on the same edge.
  - On that same edge, HIGH_SCORE <= SCORE if SCORE > HIGH_SCORE.
- Latency: the hit is sampled at edge N; SCORE, COMBO, MULT, LIVES and GAME_OVER are valid after edge N. BINARY_SCORE follows with no added register. SHOW_HIGH changes are visible combinationally.
- Throughput: one hit per cycle, back-to-back HIT_VALID accepted with no stall.
- Once SCORE reaches MAX_SCORE it stays there until the next game start.
- RST asserted mid-game returns every output to its reset value immediately (asynchronous), including HIGH_SCORE.

Test Plan:
- Reset, START, 10 PERFECT strobes back-to-back -> SCORE=1000, COMBO=10, MULT=2. An 11th PERFECT -> SCORE=1200, COMBO=11.
- Continue PERFECTs to COMBO=40 -> MULT=4 and stays 4 at COMBO=50. Then one GOOD -> SCORE increases by exactly 200.
- From COMBO=15, MULT=2, LIVES=3: one MISS -> COMBO=0, MULT=1, LIVES=2, SCORE unchanged. Two more MISSes -> LIVES=0, GAME_OVER=1, HIGH_SCORE=SCORE. SHOW_HIGH=1 -> BINARY_SCORE=HIGH_SCORE.
- In OVER: HIT_VALID PERFECT -> no change. START+HIT_VALID in the same cycle -> SCORE=0, LIVES=3, COMBO=0, HIGH_SCORE kept. A second game ending lower than the first leaves HIGH_SCORE unchanged.
- MAX_SCORE=1050 override: 11 PERFECTs -> SCORE saturates at 1050 and stays after further hits. HIT_GRADE=11 -> no register changes.
- Assert RST asynchronously mid-PLAY between clock edges -> all outputs at reset values before the next edge; START afterwards begins a clean game.
